// File: rtl/mips_multi_ctrl.sv
// mips_multi_ctrl: multicycle MIPS control unit (main FSM, ALU decoder and
// PC-enable logic) for the extended instruction set lw/sw/R-type/beq/bne/
// addi/andi/ori/slti/j/jal, with a variable-latency memory handshake,
// a bus-timeout watchdog and a trap path for illegal instructions.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   op, funct           instruction fields instr[31:26], instr[5:0]
//   zero                ALU zero flag (branch resolution)
//   mem_ready           memory completes the current access this cycle
//   mem_req             memory access request
//   pcen, memwrite, irwrite, regwrite   datapath write enables
//   alusrca, iord, zeroext              1-bit datapath selects
//   memtoreg, regdst, alusrcb, pcsrc    2-bit datapath selects
//   alucontrol          ALU operation
//   trap, cause         trap state active / cause of the last trap
//   instr_done          final cycle of a retiring instruction
//   retired             retired-instruction counter (wraps)
module mips_multi_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5,
  parameter int CNT_W    = 32,
  parameter bit TRAP_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             zeroext,
  output logic [1:0]       memtoreg,
  output logic [1:0]       regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             trap,
  output logic [1:0]       cause,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_BNEEX, S_IMMEX, S_IMMWB, S_JEX, S_JALEX, S_TRAP
  } state_t;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;

  // Counter value at which the current not-ready cycle is the MAX_WAIT-th one.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;

  state_t           state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic mem_req_c, memwrite_c, irwrite_c, regwrite_c, trap_c;
  logic pcwrite, branch, branch_ne, done_c;
  logic mem_state, timeout, funct_ok;
  logic [2:0] rtype_alu;

  // R-type funct decode
  always_comb begin
    funct_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);
  // A ready memory always beats the watchdog in the same cycle.
  assign timeout = (MAX_WAIT > 0) && mem_state && !mem_ready &&
                   (wait_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    mem_req_c  = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    trap_c     = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    zeroext    = 1'b0;
    memtoreg   = 2'b00;
    regdst     = 2'b00;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrcb   = 2'b01;
        irwrite_c = mem_ready;
        pcwrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_RTYPE:                         state_d = S_RTYPEEX;
          OP_BEQ:                           state_d = S_BEQEX;
          OP_BNE:                           state_d = S_BNEEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
          OP_J:                             state_d = S_JEX;
          OP_JAL:                           state_d = S_JALEX;
          default: begin
            if (TRAP_EN) begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c  = 1'b1;
        iord       = 1'b1;
        // The write is abandoned on the cycle the watchdog fires.
        memwrite_c = !timeout;
        if (mem_ready) state_d = S_FETCH;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        if (funct_ok) state_d = S_RTYPEWB;
        else if (TRAP_EN) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_RTYPEWB: begin
        regwrite_c = 1'b1;
        regdst     = 2'b01;
        state_d    = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = (state_q == S_BEQEX);
        branch_ne  = (state_q == S_BNEEX);
        state_d    = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroext = (op == OP_ANDI) || (op == OP_ORI);
        case (op)
          OP_ANDI: alucontrol = ALU_AND;
          OP_ORI:  alucontrol = ALU_OR;
          OP_SLTI: alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_c = 1'b1;
        zeroext    = (op == OP_ANDI) || (op == OP_ORI);
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_JALEX: begin
        // PC already holds PC+4, so the link value and the jump share one edge.
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        regwrite_c = 1'b1;
        regdst     = 2'b10;
        memtoreg   = 2'b10;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        trap_c  = 1'b1;
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Trap exits and fetch stalls never count as retirements.
  assign done_c = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                  (state_q != S_TRAP);

  assign wait_d    = (mem_state && !mem_ready && !timeout) ? wait_q + 1'b1 : '0;
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, done_c};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      cause_q   <= 2'b00;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // Side-effecting outputs are forced low for the whole reset interval.
  assign mem_req    = mem_req_c & ~reset;
  assign memwrite   = memwrite_c & ~reset;
  assign irwrite    = irwrite_c & ~reset;
  assign regwrite   = regwrite_c & ~reset;
  assign trap       = trap_c & ~reset;
  assign instr_done = done_c & ~reset;
  assign pcen       = (pcwrite | (branch & zero) | (branch_ne & ~zero)) & ~reset;
  assign cause      = cause_q;
  assign retired    = retired_q;

endmodule
